controle_rodadas: RTL

Control unit for the memory-sequence game datapath. The datapath holds the sequence ROM, the address and limit counters, the play register and the comparator. This block sequences that datapath round by round:
- clears and advances the counters,
- latches each button play and evaluates the comparison,
- runs an internal per-play timeout counter,
- drives the game-outcome and debug signals.

It sits between the top-level game circuit pins (`iniciar`, outcome LEDs) and the datapath control and status lines.

---
 rtl/controle_rodadas_pkg.sv | 15 +
 rtl/contador_timeout.sv | 18 +
 rtl/controle_rodadas.sv | 68 ++++++
 3 files changed

// File: rtl/controle_rodadas_pkg.sv
// controle_rodadas_pkg: state codes and default timeout for the round controller
package controle_rodadas_pkg;
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam logic [3:0] INICIAL         = 4'h0;
  localparam logic [3:0] PREPARACAO      = 4'h1;
  localparam logic [3:0] INICIA_RODADA   = 4'h2;
  localparam logic [3:0] ESPERA_JOGADA   = 4'h3;
  localparam logic [3:0] REGISTRA_JOGADA = 4'h4;
  localparam logic [3:0] COMPARA         = 4'h5;
  localparam logic [3:0] PROXIMA_JOGADA  = 4'h6;
  localparam logic [3:0] PROXIMA_RODADA  = 4'h7;
  localparam logic [3:0] FIM_ACERTO      = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT     = 4'hD;
  localparam logic [3:0] FIM_ERRO        = 4'hE;
endpackage

// File: rtl/contador_timeout.sv
// contador_timeout: saturating per-play counter, fim flags the last allowed cycle
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int W = $clog2(TIMEOUT_CICLOS + 1);
  logic [W-1:0] contagem;
  assign fim = contagem == W'(TIMEOUT_CICLOS - 1);
  always_ff @(posedge clock) begin
    if (!reset || zera) contagem <= '0;
    else if (conta && !fim) contagem <= contagem + W'(1);
  end
endmodule

// File: rtl/controle_rodadas.sv
// controle_rodadas: round-by-round FSM sequencing the memory-game datapath
module controle_rodadas
  import controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fim_sequencia,
  input  logic       fim_jogo,
  output logic       zera_end,
  output logic       zera_lim,
  output logic       conta_end,
  output logic       conta_lim,
  output logic       registra,
  output logic       zera_reg,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);
  logic [3:0] estado, proximo;
  logic       esperando, fim_tempo;
  assign esperando = estado == ESPERA_JOGADA;
  contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_contador (
    .clock(clock),
    .reset(reset),
    .zera(!esperando),
    .conta(esperando),
    .fim(fim_tempo)
  );
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else estado <= proximo;
  end
  // a play arriving on the expiry edge wins over the timeout
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:         proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:      proximo = INICIA_RODADA;
      INICIA_RODADA:   proximo = ESPERA_JOGADA;
      ESPERA_JOGADA:   proximo = tem_jogada ? REGISTRA_JOGADA : fim_tempo ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA_JOGADA: proximo = COMPARA;
      COMPARA:         proximo = !igual ? FIM_ERRO : !fim_sequencia ? PROXIMA_JOGADA :
                                 fim_jogo ? FIM_ACERTO : PROXIMA_RODADA;
      PROXIMA_JOGADA:  proximo = ESPERA_JOGADA;
      PROXIMA_RODADA:  proximo = INICIA_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: proximo = iniciar ? PREPARACAO : estado;
      default:         proximo = INICIAL;
    endcase
  end
  assign zera_end  = estado == PREPARACAO || estado == INICIA_RODADA;
  assign zera_lim  = estado == PREPARACAO;
  assign zera_reg  = estado == PREPARACAO;
  assign conta_end = estado == PROXIMA_JOGADA;
  assign conta_lim = estado == PROXIMA_RODADA;
  assign registra  = estado == REGISTRA_JOGADA;
  assign acertou   = estado == FIM_ACERTO;
  assign errou     = estado == FIM_ERRO || estado == FIM_TIMEOUT;
  assign timeout   = estado == FIM_TIMEOUT;
  assign pronto    = acertou || errou;
  assign db_estado = estado;
endmodule
